// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 32x32 multiplier between
// NUM_REQ requesters. One operation in flight; operands and result registered;
// the result is routed back to the requester that issued it.
// Optional statistics counters are built when MULT_ARB_STATS_EN is defined.
module mult_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16,
    localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_a_i,
    input  logic [NUM_REQ*32-1:0]   req_b_i,
    input  logic [NUM_REQ*2-1:0]    req_op_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [63:0]             rsp_result_o,
    output logic [31:0]             mul_a_o,
    output logic [31:0]             mul_b_o,
    output logic [1:0]              mul_op_sel_o,
    output logic                    mul_in_valid_o,
    input  logic                    mul_in_ready_i,
    input  logic                    mul_out_valid_i,
    output logic                    mul_out_ready_o,
    input  logic [63:0]             mul_result_i,
    output logic                    busy_o,
    output logic [OW-1:0]           owner_o
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt_o,
    output logic [CNT_W-1:0]         busy_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]              r_state;
    logic [OW-1:0]           r_owner;
    logic [OW-1:0]           r_last_grant;
    logic [31:0]             r_a;
    logic [31:0]             r_b;
    logic [1:0]              r_op;
    logic [63:0]             r_result;

    logic [NUM_REQ-1:0][31:0] w_a;
    logic [NUM_REQ-1:0][31:0] w_b;
    logic [NUM_REQ-1:0][1:0]  w_op;
    logic                     w_any;
    logic [OW-1:0]            w_gnt;
    logic                     w_accept;

    assign w_a  = req_a_i;
    assign w_b  = req_b_i;
    assign w_op = req_op_i;

    // Round-robin pick: first valid requester after the last grant, with wrap.
    always_comb begin
        int w_idx;
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_last_grant) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_any && req_valid_i[OW'(w_idx)]) begin
                w_any = 1'b1;
                w_gnt = OW'(w_idx);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_any;

    // Grant is combinational in IDLE; forced low while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (w_accept && rst_n) req_ready_o[w_gnt] = 1'b1;
    end

    // Result valid goes only to the requester that owns the operation.
    always_comb begin
        rsp_valid_o = '0;
        if (r_state == S_RESP) rsp_valid_o[r_owner] = 1'b1;
    end

    assign rsp_result_o    = r_result;
    assign mul_a_o         = r_a;
    assign mul_b_o         = r_b;
    assign mul_op_sel_o    = r_op;
    assign mul_in_valid_o  = (r_state == S_ISSUE);
    assign mul_out_ready_o = (r_state == S_WAIT);
    assign busy_o          = (r_state != S_IDLE);
    assign owner_o         = r_owner;

    // Control FSM with operand capture on grant and result capture from the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_grant <= OW'(NUM_REQ - 1);
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a          <= w_a[w_gnt];
                        r_b          <= w_b[w_gnt];
                        r_op         <= w_op[w_gnt];
                        r_owner      <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: if (mul_in_ready_i) r_state <= S_WAIT;
                S_WAIT: begin
                    if (mul_out_valid_i) begin
                        r_result <= mul_result_i;
                        r_state  <= S_RESP;
                    end
                end
                default: if (rsp_ready_i[r_owner]) r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] r_gcnt;
    logic [CNT_W-1:0]              r_busy_cnt;

    // Saturating per-requester grant counters and busy-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_accept && (r_gcnt[w_gnt] != {CNT_W{1'b1}}))
                r_gcnt[w_gnt] <= r_gcnt[w_gnt] + 1'b1;
            if (busy_o && (r_busy_cnt != {CNT_W{1'b1}}))
                r_busy_cnt <= r_busy_cnt + 1'b1;
        end
    end

    assign grant_cnt_o = r_gcnt;
    assign busy_cnt_o  = r_busy_cnt;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NUM_REQ=2). A small behavioural
// multiplier answers on the mul_* side; expected results are hand-computed.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_a_i;
    logic [63:0] req_b_i;
    logic [3:0]  req_op_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [63:0] rsp_result_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [1:0]  mul_op_sel_o;
    logic        mul_in_valid_o;
    logic        mul_in_ready_i;
    logic        mul_out_valid_i;
    logic        mul_out_ready_o;
    logic [63:0] mul_result_i;
    logic        busy_o;
    logic [0:0]  owner_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] r_prod = 64'd0;

    mult_share_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_op_sel_o(mul_op_sel_o),
        .mul_in_valid_o(mul_in_valid_o), .mul_in_ready_i(mul_in_ready_i),
        .mul_out_valid_i(mul_out_valid_i), .mul_out_ready_o(mul_out_ready_o),
        .mul_result_i(mul_result_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [63:0] ea, eb;
        ea = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (op[1])       ? {32'd0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Behavioural multiplier: captures the product on the input handshake.
    always @(posedge clk)
        if (mul_in_valid_o && mul_in_ready_i)
            r_prod <= mul_model(mul_a_o, mul_b_o, mul_op_sel_o);

    assign mul_result_i = r_prod;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full transaction from IDLE with the requests already driven.
    task automatic do_txn(input string tag, input int g, input logic [63:0] res);
        logic [1:0] oh;
        oh = (g == 0) ? 2'b01 : 2'b10;
        #1;
        chk({tag, "_ready"}, 64'(req_ready_o), 64'(oh));
        cyc();
        #1;
        chk({tag, "_owner"}, 64'(owner_o), 64'(g));
        chk({tag, "_invalid"}, 64'(mul_in_valid_o), 64'd1);
        mul_in_ready_i = 1'b1;
        cyc();
        mul_in_ready_i  = 1'b0;
        mul_out_valid_i = 1'b1;
        cyc();
        mul_out_valid_i = 1'b0;
        #1;
        chk({tag, "_rspvalid"}, 64'(rsp_valid_o), 64'(oh));
        chk({tag, "_result"}, rsp_result_o, res);
        rsp_ready_i = oh;
        cyc();
        rsp_ready_i = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_i = 2'b01; req_a_i = '0; req_b_i = '0; req_op_i = '0;
        rsp_ready_i = '0; mul_in_ready_i = 1'b0; mul_out_valid_i = 1'b0;
        #2;
        // Reset state: everything low even with a request pending.
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rspvalid", 64'(rsp_valid_o), 64'd0);
        chk("rst_invalid", 64'(mul_in_valid_o), 64'd0);
        chk("rst_result", rsp_result_o, 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        cyc();
        rst_n = 1'b1; req_valid_i = 2'b00;
        cyc();

        // Single requester 0: 10*20.
        req_valid_i = 2'b01; req_a_i[31:0] = 32'd10; req_b_i[31:0] = 32'd20; req_op_i[1:0] = 2'b00;
        #1;
        chk("t1_ready", 64'(req_ready_o), 64'd1);
        cyc();
        req_valid_i = 2'b00;
        #1;
        chk("t1_ready_gone", 64'(req_ready_o), 64'd0);
        chk("t1_mula", 64'(mul_a_o), 64'd10);
        chk("t1_mulb", 64'(mul_b_o), 64'd20);
        chk("t1_busy", 64'(busy_o), 64'd1);
        mul_in_ready_i = 1'b1;
        cyc();
        mul_in_ready_i = 1'b0;
        #1;
        chk("t1_outready", 64'(mul_out_ready_o), 64'd1);
        chk("t1_no_rsp", 64'(rsp_valid_o), 64'd0);
        mul_out_valid_i = 1'b1;
        cyc();
        mul_out_valid_i = 1'b0;
        #1;
        chk("t1_rspvalid", 64'(rsp_valid_o), 64'd1);
        chk("t1_result", rsp_result_o, 64'd200);
        chk("t1_busy_resp", 64'(busy_o), 64'd1);
        rsp_ready_i = 2'b01;
        cyc();
        rsp_ready_i = 2'b00;
        #1;
        chk("t1_busy_end", 64'(busy_o), 64'd0);
        chk("t1_result_hold", rsp_result_o, 64'd200);

        // Fairness from reset: both valid, grants 0,1,0,1.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_a_i = {32'd500, 32'd1000};
        req_b_i = {32'd400, 32'hFFFF_FE0C};
        req_op_i = {2'b11, 2'b01};
        req_valid_i = 2'b11;
        do_txn("rr0", 0, 64'hFFFF_FFFF_FFF8_5EE0);
        do_txn("rr1", 1, 64'd200000);
        do_txn("rr2", 0, 64'hFFFF_FFFF_FFF8_5EE0);
        do_txn("rr3", 1, 64'd200000);

        // Backpressure on both multiplier input and response.
        req_valid_i = 2'b01; req_a_i[31:0] = 32'd7; req_b_i[31:0] = 32'd6; req_op_i[1:0] = 2'b00;
        #1;
        chk("bp_ready", 64'(req_ready_o), 64'd1);
        cyc();
        req_valid_i = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_issue_hold", 64'(mul_in_valid_o), 64'd1);
            chk("bp_issue_mula", 64'(mul_a_o), 64'd7);
            chk("bp_issue_nogrant", 64'(req_ready_o), 64'd0);
            cyc();
        end
        mul_in_ready_i = 1'b1;
        cyc();
        mul_in_ready_i = 1'b0; mul_out_valid_i = 1'b1;
        cyc();
        mul_out_valid_i = 1'b0;
        rsp_ready_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_resp_valid", 64'(rsp_valid_o), 64'd1);
            chk("bp_resp_result", rsp_result_o, 64'd42);
            chk("bp_resp_nogrant", 64'(req_ready_o), 64'd0);
            cyc();
        end
        rsp_ready_i = 2'b01;
        cyc();
        rsp_ready_i = 2'b00;
        #1;
        chk("bp_next_ready", 64'(req_ready_o), 64'd2);
        req_valid_i = 2'b00;
        cyc();

        // Stray multiplier output in IDLE and ISSUE.
        mul_out_valid_i = 1'b1;
        cyc();
        #1;
        chk("stray_idle_rsp", 64'(rsp_valid_o), 64'd0);
        chk("stray_idle_oready", 64'(mul_out_ready_o), 64'd0);
        chk("stray_idle_busy", 64'(busy_o), 64'd0);
        req_valid_i = 2'b10; req_a_i[63:32] = 32'd3; req_b_i[63:32] = 32'd5; req_op_i[3:2] = 2'b11;
        #1;
        chk("stray_ready", 64'(req_ready_o), 64'd2);
        cyc();
        req_valid_i = 2'b00;
        cyc();
        #1;
        chk("stray_issue_hold", 64'(mul_in_valid_o), 64'd1);
        chk("stray_issue_oready", 64'(mul_out_ready_o), 64'd0);
        chk("stray_issue_rsp", 64'(rsp_valid_o), 64'd0);
        mul_out_valid_i = 1'b0; mul_in_ready_i = 1'b1;
        cyc();
        mul_in_ready_i = 1'b0; mul_out_valid_i = 1'b1;
        cyc();
        mul_out_valid_i = 1'b0;
        #1;
        chk("stray_rspvalid", 64'(rsp_valid_o), 64'd2);
        chk("stray_result", rsp_result_o, 64'd15);
        rsp_ready_i = 2'b10;
        cyc();
        rsp_ready_i = 2'b00;

        // Reset during WAIT: outputs drop at once, old result never shows.
        req_valid_i = 2'b01; req_a_i[31:0] = 32'd9; req_b_i[31:0] = 32'd9; req_op_i[1:0] = 2'b00;
        cyc();
        req_valid_i = 2'b00; mul_in_ready_i = 1'b1;
        cyc();
        mul_in_ready_i = 1'b0;
        #1;
        chk("rw_in_wait", 64'(mul_out_ready_o), 64'd1);
        rst_n = 1'b0; req_valid_i = 2'b11;
        #1;
        chk("rw_oready", 64'(mul_out_ready_o), 64'd0);
        chk("rw_busy", 64'(busy_o), 64'd0);
        chk("rw_ready", 64'(req_ready_o), 64'd0);
        chk("rw_result", rsp_result_o, 64'd0);
        chk("rw_mula", 64'(mul_a_o), 64'd0);
        chk("rw_owner", 64'(owner_o), 64'd1 - 64'd1);
        cyc();
        rst_n = 1'b1; req_valid_i = 2'b00; mul_out_valid_i = 1'b1;
        cyc();
        mul_out_valid_i = 1'b0;
        #1;
        chk("rw_no_stale_rsp", 64'(rsp_valid_o), 64'd0);
        chk("rw_idle", 64'(busy_o), 64'd0);
        req_a_i[31:0] = 32'd4; req_b_i[31:0] = 32'd4; req_valid_i = 2'b11;
        do_txn("rw_regrant", 0, 64'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one multiplier_32x32 (valid/ready in, valid/ready out, 64-bit resultado) between NUM_REQ requesters, e.g. two issue lanes or a core plus a divider-helper.
- Round-robin arbitration; one operation in flight at a time.
- Operands and results are registered.
- Each result is routed back to the requester that issued it.
- Sits between the requesters and the multiplier instance in the M-extension unit.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CNT_W, 16, width of each statistics counter (used only with MULT_ARB_STATS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high
req_a_i  in  NUM_REQ*32  operand a, requester i at bits [32i+31:32i]
req_b_i  in  NUM_REQ*32  operand b, same packing
req_op_i  in  NUM_REQ*2  op_sel (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU), packed
rsp_valid_o  out  NUM_REQ  per-requester result valid; at most one bit high
rsp_ready_i  in  NUM_REQ  per-requester result accept
rsp_result_o  out  64  result, shared by all requesters
mul_a_o  out  32  to multiplier a
mul_b_o  out  32  to multiplier b
mul_op_sel_o  out  2  to multiplier op_sel
mul_in_valid_o  out  1  to multiplier in_valid_i
mul_in_ready_i  in  1  from multiplier in_ready_o
mul_out_valid_i  in  1  from multiplier out_valid_o
mul_out_ready_o  out  1  to multiplier out_ready_i
mul_result_i  in  64  from multiplier resultado
busy_o  out  1  high whenever state != IDLE
owner_o  out  max(1,$clog2(NUM_REQ))  index of the current or last granted requester

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - owner, operand registers and result register = 0.
  - All outputs 0; req_ready_o is combinational and therefore also 0 outside IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid_i[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready_o[g]=1 in the same cycle (combinational).
  - On that edge: capture a/b/op of g, owner<=g, last_grant<=g, go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - mul_in_valid_o=1, driven from registered operands that are stable until accepted.
  - mul_in_ready_i=1 → WAIT. Otherwise hold indefinitely.
- WAIT:
  - mul_out_ready_o=1.
  - mul_out_valid_i=1 → result_q<=mul_result_i, go to RESP.
- RESP:
  - rsp_valid_o[owner]=1; rsp_result_o=result_q.
  - rsp_ready_i[owner]=1 → IDLE.
  - rsp_ready_i of non-owners is ignored.
- rsp_result_o holds its last value outside RESP.
- mul_out_ready_o=0 outside WAIT; stray mul_out_valid_i is ignored.
- Requester inputs are ignored outside IDLE. A requester may drop valid freely; only the acceptance cycle matters.
- Latency: accept at cycle T → mul_in_valid_o at T+1 → rsp_valid_o at earliest T+3 (0-cycle multiplier response) plus multiplier latency.
- Back-to-back: a new grant is possible the cycle after the response handshake.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0...
- A single active requester wins every time.
- Reset mid-operation: immediate return to IDLE with all outputs 0; any in-flight result is discarded and never reported.
- Arithmetic: the 64-bit result is passed through unmodified; op interpretation belongs to the multiplier.

Optional Feature:
MULT_ARB_STATS_EN
- Defined:
  - Adds output grant_cnt_o (NUM_REQ*CNT_W): per-requester grant counters, incremented on each IDLE acceptance.
  - Adds output busy_cnt_o (CNT_W): counts cycles with busy_o=1.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single requester 0: a=10, b=20, op=00 → req_ready_o=01 for one cycle; mul_a_o=10 while mul_in_valid_o=1; rsp_valid_o=01 with rsp_result_o=200; busy_o falls after the response handshake.
- Both requesters valid continuously:
  - req0 a=1000, b=-500, op=01; req1 a=500, b=400, op=11.
  - → grants alternate 0,1,0,1 starting with 0 after reset.
  - → req0 gets 0xFFFFFFFF_FFF85EE0 (full 64-bit product -500000); req1 gets 200000.
- Backpressure: hold mul_in_ready_i=0 for 5 cycles in ISSUE, then rsp_ready_i=0 for 4 cycles in RESP → operands and rsp_result_o stay stable, no new grant; the non-owner asserting rsp_ready_i has no effect.
- Stray mul_out_valid_i=1 while IDLE or ISSUE → ignored, mul_out_ready_o=0, no rsp_valid_o.
- Reset asserted in WAIT → all outputs 0 asynchronously; after release, requester 0 is granted first and the old result is never presented.
- With MULT_ARB_STATS_EN: 3 grants to req0 and 2 to req1 → grant_cnt_o = {2,3}; busy_cnt_o equals the measured busy cycles. Saturation checked with CNT_W=4 (stops at 15).
